// File: rtl/eq_phase_pkg.sv
// Shared constants, state encoding and helpers for the E/Q phase tracker.
package eq_phase_pkg;

  localparam int unsigned PHASE_COUNT = 12;

  localparam logic [3:0] TICK_Q_RISE = 4'd0;
  localparam logic [3:0] TICK_E_RISE = 4'd3;
  localparam logic [3:0] TICK_Q_FALL = 4'd6;
  localparam logic [3:0] TICK_E_FALL = 4'd9;
  localparam logic [3:0] TICK_LAST   = 4'(PHASE_COUNT - 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef struct packed {
    logic q_rise;
    logic e_rise;
    logic q_fall;
    logic e_fall;
    logic bad;
  } period_flags_t;

  function automatic logic [PHASE_COUNT-1:0] tick_onehot(input logic [3:0] tick);
    logic [PHASE_COUNT-1:0] oh;
    for (int i = 0; i < PHASE_COUNT; i++) begin
      oh[i] = (tick == 4'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/e_q_phase_tracker_if.sv
// Bus bundle between E/Q synchronizers, the phase tracker and slaved bus logic.
interface e_q_phase_tracker_if;
  logic        e_in;
  logic        q_in;
  logic        locked;
  logic [11:0] phase;
  logic        en_q;
  logic        en_e;
  logic        en_q_n;
  logic        en_e_n;
  logic        err;
  logic [7:0]  err_count;

  modport master (
    output e_in, q_in,
    input  locked, phase, en_q, en_e, en_q_n, en_e_n, err, err_count
  );

  modport slave (
    input  e_in, q_in,
    output locked, phase, en_q, en_e, en_q_n, en_e_n, err, err_count
  );
endinterface

// File: rtl/eq_edge_detect.sv
// Rise/fall detector for one sampled clock level.
// ROBOTRON_EQ_GLITCH_FILTER_EN adds a 2-sample agreement filter ahead of detection.
module eq_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;
  logic w_level;

`ifdef ROBOTRON_EQ_GLITCH_FILTER_EN
  logic r_sample;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sample <= 1'b0;
    else        r_sample <= i_level;
  end

  // Accept a new level only when two consecutive samples agree.
  assign w_level = (i_level == r_sample) ? i_level : r_prev;
`else
  assign w_level = i_level;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign o_rise = ~r_prev & w_level;
  assign o_fall = r_prev & ~w_level;

endmodule

// File: rtl/e_q_phase_tracker.sv
// Recovers the 12-tick E/Q phase from sampled E and Q levels, declares lock and
// regenerates one-hot phase plus edge enables. Optional: ROBOTRON_EQ_GLITCH_FILTER_EN.
module e_q_phase_tracker
  import eq_phase_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 2,
  parameter int unsigned MISS_LIMIT  = 2
) (
  input logic                clk,
  input logic                rst_n,
  e_q_phase_tracker_if.slave eq
);

  localparam logic [3:0] LockTarget = 4'(LOCK_CYCLES);
  localparam logic [3:0] MissTarget = 4'(MISS_LIMIT);

  logic w_q_rise, w_q_fall, w_e_rise, w_e_fall;

  eq_edge_detect u_q_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_level(eq.q_in),
    .o_rise (w_q_rise),
    .o_fall (w_q_fall)
  );

  eq_edge_detect u_e_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_level(eq.e_in),
    .o_rise (w_e_rise),
    .o_fall (w_e_fall)
  );

  logic [1:0]             r_state, w_state_d;
  logic [3:0]             r_tick, w_tick_d;
  period_flags_t          r_flags, w_flags_cur, w_flags_d;
  logic [3:0]             r_good_cnt, w_good_d;
  logic [3:0]             r_miss_cnt, w_miss_d;
  logic                   r_skip, w_skip_d;
  logic                   w_err_d, w_period_good, w_lock_d;
  logic                   r_locked, r_err;
  logic [PHASE_COUNT-1:0] r_phase;
  logic [3:0]             r_en;
  logic [7:0]             r_err_count;

  always_comb begin
    w_flags_cur = r_flags;
    if (w_q_rise) begin
      if (r_tick == TICK_Q_RISE) w_flags_cur.q_rise = 1'b1;
      else                       w_flags_cur.bad    = 1'b1;
    end
    if (w_e_rise) begin
      if (r_tick == TICK_E_RISE) w_flags_cur.e_rise = 1'b1;
      else                       w_flags_cur.bad    = 1'b1;
    end
    if (w_q_fall) begin
      if (r_tick == TICK_Q_FALL) w_flags_cur.q_fall = 1'b1;
      else                       w_flags_cur.bad    = 1'b1;
    end
    if (w_e_fall) begin
      if (r_tick == TICK_E_FALL) w_flags_cur.e_fall = 1'b1;
      else                       w_flags_cur.bad    = 1'b1;
    end
    w_period_good = w_flags_cur.q_rise & w_flags_cur.e_rise & w_flags_cur.q_fall &
                    w_flags_cur.e_fall & ~w_flags_cur.bad;

    w_state_d = r_state;
    w_tick_d  = (r_tick == TICK_LAST) ? 4'd0 : r_tick + 4'd1;
    w_flags_d = (r_tick == TICK_LAST) ? '0 : w_flags_cur;
    w_good_d  = r_good_cnt;
    w_miss_d  = r_miss_cnt;
    w_skip_d  = 1'b0;
    w_err_d   = 1'b0;

    case (r_state)
      ST_SEARCH: begin
        w_tick_d  = 4'd0;
        w_flags_d = '0;
        // r_skip models SEARCH being entered one cycle after a failed acquisition.
        if (w_q_rise && !r_skip) begin
          w_tick_d         = 4'd1;
          w_good_d         = 4'd0;
          w_flags_d.q_rise = 1'b1;
          w_state_d        = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (r_tick == TICK_LAST) begin
          if (w_period_good) begin
            w_good_d = r_good_cnt + 4'd1;
            if (w_good_d == LockTarget) begin
              w_state_d = ST_LOCKED;
              w_miss_d  = 4'd0;
            end
          end else begin
            w_state_d = ST_SEARCH;
            w_skip_d  = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (r_tick == TICK_LAST) begin
          if (w_period_good) begin
            w_miss_d = 4'd0;
          end else begin
            w_err_d  = 1'b1;
            w_miss_d = r_miss_cnt + 4'd1;
            if (w_miss_d == MissTarget) w_state_d = ST_SEARCH;
          end
        end
      end
      default: w_state_d = ST_SEARCH;
    endcase

    w_lock_d = (w_state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_tick      <= 4'd0;
      r_flags     <= '0;
      r_good_cnt  <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_skip      <= 1'b0;
      r_locked    <= 1'b0;
      r_phase     <= '0;
      r_en        <= 4'd0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_state    <= w_state_d;
      r_tick     <= w_tick_d;
      r_flags    <= w_flags_d;
      r_good_cnt <= w_good_d;
      r_miss_cnt <= w_miss_d;
      r_skip     <= w_skip_d;
      r_locked   <= w_lock_d;
      r_phase    <= w_lock_d ? tick_onehot(r_tick) : '0;
      r_en       <= w_lock_d ? {r_tick == TICK_Q_RISE, r_tick == TICK_E_RISE,
                                r_tick == TICK_Q_FALL, r_tick == TICK_E_FALL} : 4'd0;
      r_err      <= w_err_d;
      if (w_err_d && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign eq.locked    = r_locked;
  assign eq.phase     = r_phase;
  assign eq.en_q      = r_en[3];
  assign eq.en_e      = r_en[2];
  assign eq.en_q_n    = r_en[1];
  assign eq.en_e_n    = r_en[0];
  assign eq.err       = r_err;
  assign eq.err_count = r_err_count;

endmodule

// File: doc/e_q_phase_tracker.md
Name: e_q_phase_tracker

Overview:
- Receive-side counterpart of the master E/Q enable generator.
- Samples externally supplied E and Q clock levels (one sample per clk, 12 clk per E period) and recovers the 12-tick phase position.
- Declares lock once the phase is stable and regenerates one-hot phase and the four edge enables, so logic slaved to a real 6809/board clock can run on the same enable scheme as the internal generator.
- Sits between the input synchronizers for E/Q and any bus-cycle logic.

Parameters:
LOCK_CYCLES, 2, consecutive good E periods (counting the first, triggering period) needed to declare lock; legal 1..15
MISS_LIMIT, 2, consecutive bad E periods while locked before lock is dropped; legal 1..15

Ports:
clk  input  1  system clock, 12x E frequency
rst_n  input  1  synchronous reset, active-low
e_in  input  1  sampled E level (already synchronized)
q_in  input  1  sampled Q level (already synchronized)
locked  output  1  phase lock established
phase  output  12  one-hot recovered tick; bit n high when current tick==n; all zero when not locked
en_q  output  1  pulse at tick 0 (Q rise) while locked
en_e  output  1  pulse at tick 3 (E rise) while locked
en_q_n  output  1  pulse at tick 6 (Q fall) while locked
en_e_n  output  1  pulse at tick 9 (E fall) while locked
err  output  1  one-clk pulse for each bad period evaluated while locked
err_count  output  8  saturating count of err pulses; cleared only by reset

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset: state=SEARCH, tick=0, good_cnt=0, miss_cnt=0, locked=0, phase=0, all en_*=0, err=0, err_count=0, e_prev=q_prev=0.
- Edge detection: compare each sample with the previous one. Rise means prev=0 and now=1; fall means prev=1 and now=0.
- Expected pattern (tick numbering of the cycle in which the edge is seen):
  - tick 0: Q rise
  - tick 3: E rise
  - tick 6: Q fall
  - tick 9: E fall
  - any other edge, or any of the four missing, makes the period bad.
- Evaluation: tick is a 0..11 wrap counter. Per-period flags accumulate during ticks 0..11; the period is evaluated at tick 11, including any edge seen at tick 11 itself.
- SEARCH: tick is held at 0. A Q rise makes that cycle tick 0; tick goes to 1 next, good_cnt clears, flags start with the Q-rise flag set, state moves to ACQUIRE. Other edges are ignored.
- ACQUIRE, evaluation at tick 11:
  - good period: good_cnt+1; if this reaches LOCK_CYCLES, go to LOCKED.
  - bad period: go to SEARCH.
  - A Q rise in the cycle immediately after a bad evaluation is not seen, because SEARCH is entered one cycle late; resync happens on the next Q rise.
- LOCKED, evaluation at tick 11:
  - good period: miss_cnt=0.
  - bad period: err pulses one clk, err_count+1 (saturates at 255), miss_cnt+1; if miss_cnt reaches MISS_LIMIT, go to SEARCH.
  - tick free-runs and is never re-aligned while locked.
- Output timing:
  - locked, phase and en_* are registered and reflect tick/state one clk late. en_q is high in the cycle after the tick-0 sample; the other enables follow the same rule.
  - locked rises one clk after the final good evaluation in ACQUIRE and falls one clk after the final bad evaluation.
  - When locked=0, phase and en_* are 0.
- Reset wins over all events in the same cycle. Reset mid-period discards all partial state.

Optional Feature:
ROBOTRON_EQ_GLITCH_FILTER_EN
- Defined: each of e_in and q_in passes through a 2-sample agreement filter before edge detection. A level is accepted only after 2 equal consecutive samples, so a single-sample glitch is rejected. All edges and outputs shift one additional clk later; tick alignment is unchanged relative to the filtered signal.
- Undefined: raw samples feed edge detection directly.

Decomposition:
- Package eq_phase_pkg holds:
  - PHASE_COUNT=12
  - TICK_Q_RISE=0, TICK_E_RISE=3, TICK_Q_FALL=6, TICK_E_FALL=9
  - state encoding SEARCH/ACQUIRE/LOCKED
- Sub-module eq_edge_detect, instantiated once per input: holds the prev register, the optional glitch filter, and the rise/fall outputs.

Test Plan:
- Ideal pattern (Q high ticks 0-5, E high ticks 3-8), default parameters, started from reset:
  - locked rises 1 clk after the tick-11 evaluation of the 2nd period (cycle 24 after the first Q rise).
  - Thereafter en_q, en_e, en_q_n, en_e_n repeat every 12 clk at relative offsets 0/3/6/9.
- While locked, move one E-rise to tick 4 for one period:
  - err pulses once and err_count becomes 1; locked stays 1.
  - Repeat for 2 consecutive periods: locked drops, then relocks 2 periods after the pattern is clean again.
- In ACQUIRE, insert an extra Q toggle at tick 7: return to SEARCH, locked stays 0, and lock is reacquired on the following clean periods.
- rst_n=0 held for 1 clk while locked mid-period: next cycle all outputs are 0 and err_count=0.
- Force 300 bad periods with MISS_LIMIT=15 and the pattern kept good enough to stay locked: err_count saturates at 255.
- ROBOTRON_EQ_GLITCH_FILTER_EN defined, 1-clk glitch on e_in at tick 5: no err, lock held; without the macro, err=1.
